// File: rtl/zl_ts_pkg.sv
// Shared definitions for the transport-stream null inserter: packet
// geometry, sync byte, null-packet header bytes and the FSM encoding.
package zl_ts_pkg;

  localparam int TS_PKT_LEN = 188;

  localparam logic [7:0] TS_SYNC    = 8'h47;
  localparam logic [7:0] NULL_HDR1  = 8'h1F;
  localparam logic [7:0] NULL_HDR2  = 8'hFF;
  localparam logic [7:0] NULL_HDR3  = 8'h10;
  localparam logic [7:0] NULL_FILL  = 8'hFF;

  // Last byte index within a packet slot.
  localparam logic [7:0] TS_LAST_IDX = 8'(TS_PKT_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_NULL = 2'd2
  } ts_state_e;

  // Byte of a DVB null packet (PID 0x1FFF, payload only) at position idx.
  function automatic logic [7:0] null_byte(input logic [7:0] idx);
    logic [7:0] b;
    case (idx)
      8'd0:    b = TS_SYNC;
      8'd1:    b = NULL_HDR1;
      8'd2:    b = NULL_HDR2;
      8'd3:    b = NULL_HDR3;
      default: b = NULL_FILL;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/zl_sat_counter.sv
// Free-running event counter that sticks at all-ones instead of wrapping,
// so a statistics read never shows a misleadingly small value.
module zl_sat_counter #(
  parameter int Width = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [Width-1:0] count
);

  // Count enabled events until the all-ones ceiling is reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/zl_ts_null_inserter.sv
// Read-side consumer of the TS FIFO. Each packet slot is either a whole
// 188-byte packet drained from the FIFO with zero latency, or a DVB null
// packet when a full packet is not yet buffered. One IDLE bubble separates
// slots, which is where the forward/null decision is made.
module zl_ts_null_inserter
  import zl_ts_pkg::*;
#(
  parameter int Used_width = 9,
  parameter int Cnt_width  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_req,
  output logic                  in_ack,
  input  logic [7:0]            in_data,
  input  logic [Used_width-1:0] in_used,
  output logic                  out_req,
  input  logic                  out_ack,
  output logic [7:0]            out_data,
  output logic                  sync_err,
  output logic [Cnt_width-1:0]  fwd_cnt,
  output logic [Cnt_width-1:0]  null_cnt
);

  localparam logic [Used_width-1:0] PKT_USED = Used_width'(TS_PKT_LEN);

  ts_state_e  state;
  ts_state_e  state_nxt;
  logic [7:0] bcnt;
  logic [7:0] bcnt_nxt;
  logic       sync_err_nxt;
  logic       fwd_inc;
  logic       null_inc;

  // State, byte position and the registered sync-error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      bcnt     <= '0;
      sync_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      bcnt     <= bcnt_nxt;
      sync_err <= sync_err_nxt;
    end
  end

  // Slot sequencing and the combinational FIFO/downstream handshakes.
  always_comb begin
    state_nxt    = state;
    bcnt_nxt     = bcnt;
    in_ack       = 1'b0;
    out_req      = 1'b0;
    out_data     = 8'h00;
    sync_err_nxt = 1'b0;
    fwd_inc      = 1'b0;
    null_inc     = 1'b0;
    case (state)
      ST_IDLE: begin
        // in_used can only under-report here, so >= 188 guarantees a
        // whole packet is available for the next slot.
        state_nxt = (in_used >= PKT_USED) ? ST_FWD : ST_NULL;
      end
      ST_FWD: begin
        out_data = in_data;
        if ((bcnt == 8'd0) && in_req && (in_data != TS_SYNC)) begin
          // Misaligned head: discard one byte and retry next slot.
          in_ack       = 1'b1;
          sync_err_nxt = 1'b1;
          state_nxt    = ST_IDLE;
        end else begin
          out_req = in_req;
          in_ack  = in_req && out_ack;
          if (in_ack) begin
            if (bcnt == TS_LAST_IDX) begin
              bcnt_nxt  = '0;
              fwd_inc   = 1'b1;
              state_nxt = ST_IDLE;
            end else begin
              bcnt_nxt = bcnt + 8'd1;
            end
          end
        end
      end
      ST_NULL: begin
        out_req  = 1'b1;
        out_data = null_byte(bcnt);
        if (out_ack) begin
          if (bcnt == TS_LAST_IDX) begin
            bcnt_nxt  = '0;
            null_inc  = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            bcnt_nxt = bcnt + 8'd1;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        bcnt_nxt  = '0;
      end
    endcase
  end

  zl_sat_counter #(.Width(Cnt_width)) u_fwd_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (fwd_inc),
    .count (fwd_cnt)
  );

  zl_sat_counter #(.Width(Cnt_width)) u_null_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (null_inc),
    .count (null_cnt)
  );

endmodule

// File: doc/zl_ts_null_inserter.md
# zl_ts_null_inserter

Single-clock consumer on the read side of the transport-stream FIFO. It drains whole 188-byte TS packets through the FIFO's req/ack output port and, when a full packet is not buffered, emits DVB null packets instead. The downstream modulator chain therefore sees an uninterrupted, packet-aligned byte stream.

## Interface
- `Used_width`, 9: width of the `in_used` fill-level input; must be ≥ 8 so that 188 is representable.
- `Cnt_width`, 16: width of the statistics counters.

- `clk`  in  1  block clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_req`  in  1  FIFO has a byte available (FIFO `out_req`).
- `in_ack`  out  1  byte consumed this cycle (drives FIFO `out_ack`).
- `in_data`  in  8  FIFO head byte, showahead.
- `in_used`  in  Used_width  FIFO read-side fill level.
- `out_req`  out  1  byte valid toward downstream.
- `out_ack`  in  1  downstream accepts byte.
- `out_data`  out  8  output byte.
- `sync_err`  out  1  one-cycle pulse: a forwarded packet did not start with 0x47.
- `fwd_cnt`  out  Cnt_width  forwarded packets, saturating.
- `null_cnt`  out  Cnt_width  null packets emitted, saturating.

## Operation
- FSM states: IDLE, FWD, NULL.
- IDLE: `out_req` = 0 and `in_ack` = 0.
  - If `in_used` ≥ 188: go to FWD.
  - Else: go to NULL.
  - The decision is taken from `in_used` sampled in IDLE. That value can only under-report, because this block is the sole reader.
- FWD: pass-through with zero latency.
  - `out_req` = `in_req`; `out_data` = `in_data`; `in_ack` = `in_req` && `out_ack`.
  - Byte counter `bcnt` (0..187) increments on each `in_ack`.
- FWD first byte (`bcnt` = 0) ≠ 0x47:
  - `in_ack` = 1 and `out_req` = 0, so the byte is dropped.
  - `sync_err` pulses; return to IDLE.
  - Realignment happens one byte per packet slot.
- FWD on `in_ack` with `bcnt` = 187: increment `fwd_cnt`, clear `bcnt`, go to IDLE.
- NULL:
  - `out_req` = 1; `in_ack` = 0.
  - `out_data` by `bcnt`: 0 → 0x47, 1 → 0x1F, 2 → 0xFF, 3 → 0x10, 4..187 → 0xFF.
  - `bcnt` increments on `out_ack`.
  - On `out_ack` with `bcnt` = 187: increment `null_cnt`, clear `bcnt`, go to IDLE.
- Counters saturate at all-ones and do not wrap.
- A packet is never interrupted. If `in_req` drops during FWD, the block stalls with `out_req` = 0 and no null bytes are interleaved.

## Timing
- Reset values: state IDLE, `bcnt` 0, `out_req` 0, `in_ack` 0, `out_data` 0x00, `sync_err` 0, `fwd_cnt` 0, `null_cnt` 0.
- `out_data` is 0x00 whenever the state is IDLE.
- Reset deassertion: IDLE on the first clock, first output byte valid on the second clock.
- Exactly one IDLE bubble cycle per 188-byte packet, so maximum throughput is 188/189 bytes per clock.
- `in_ack` and `out_req` are combinational from state, `bcnt`, `in_req`, `out_ack`, and `in_data` (first-byte check). There is no combinational path from `out_ack` to `out_req`.
- `out_data` must be held stable while `out_req` && !`out_ack`.
- `sync_err` is registered and asserts the cycle after the drop.
- Asserting `rst_n` mid-packet aborts immediately. The partial packet is not completed, and the downstream must resynchronise on 0x47.
- `in_used` = 187 goes to NULL; `in_used` = 188 goes to FWD.

## Structure
- Shared package `zl_ts_pkg`:
  - constants `TS_PKT_LEN` = 188 and `TS_SYNC` = 0x47;
  - null-header bytes 0x1F, 0xFF, 0x10;
  - FSM state encoding.
- One sub-module, `zl_sat_counter`: parameterised saturating counter with increment enable, instantiated twice.

## Test plan
- FIFO empty, `out_ack` held 1: emits back-to-back null packets with bytes 47 1F FF 10 FF…, one bubble between packets; `null_cnt` increments every 189 cycles.
- FIFO preloaded with two valid packets (`in_used` = 376), `out_ack` = 1: 376 bytes forwarded unchanged, `fwd_cnt` = 2, then null packets follow.
- `in_used` = 187 with 187 bytes queued: null packet emitted and `in_ack` never asserts; after the 188th byte is written, the next IDLE selects FWD.
- Random `out_ack` back-pressure at 50%: `out_data` stable while stalled; the output byte stream equals the input packets with nulls inserted only at 188-byte boundaries.
- Packet whose first byte is 0x00: one byte dropped, `sync_err` pulses once, `fwd_cnt` unchanged; after realignment (repeated drops until 0x47 is at the head) the packets that follow are forwarded intact.
- `rst_n` asserted at `bcnt` = 100 of a null packet: `out_req` = 0 and the counters read 0 immediately; after release, the next output byte is 0x47.
